// File: rtl/cache_wb_pkg.sv
// Shared types and helpers for the write-back direct-mapped cache.
// Holds the controller state encoding, the line-store operation codes and a clog2 for derived widths.
package cache_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND,
    ST_FLUSH
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_WORD,
    OP_FILL,
    OP_CLEAN,
    OP_INVAL
  } store_op_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage for the cache: data/tag arrays plus valid/dirty bit vectors.
// One index serves both the combinational read and the single write operation of each cycle.
module cache_line_store
  import cache_wb_pkg::*;
#(
  parameter int WORD_W         = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 8,
  parameter int TAG_W          = 3,
  parameter int IDX_W          = 3,
  parameter int OFF_W          = 2,
  parameter int LINE_W         = WORD_W * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  input  store_op_t         op,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              wr_merge,
  output logic [LINE_W-1:0] rd_line,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty
);

  logic [LINE_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [LINE_W-1:0] base_line, line_d;
  logic              merge_en;

  assign base_line = (op == OP_FILL) ? wr_line : data_mem[idx];
  assign merge_en  = (op == OP_WORD) || ((op == OP_FILL) && wr_merge);

  // A fill carrying a pending write overlays the processor word onto the fetched line.
  for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
    assign line_d[gi*WORD_W +: WORD_W] = (merge_en && (wr_off == OFF_W'(gi)))
                                         ? wr_word : base_line[gi*WORD_W +: WORD_W];
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    case (op)
      OP_WORD:  dirty_d[idx] = 1'b1;
      OP_FILL:  begin valid_d[idx] = 1'b1; dirty_d[idx] = wr_merge; end
      OP_CLEAN: dirty_d[idx] = 1'b0;
      OP_INVAL: begin valid_d[idx] = 1'b0; dirty_d[idx] = 1'b0; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (op == OP_WORD || op == OP_FILL) data_mem[idx] <= line_d;
    if (op == OP_FILL) tag_mem[idx] <= wr_tag;
  end

  assign rd_line  = data_mem[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/cache_wb_dm.sv
// Direct-mapped write-back, write-allocate cache controller with victim write-back and flush.
// The FSM drives one line-store operation per cycle; the flush counter steers the store index while flushing.
module cache_wb_dm
  import cache_wb_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int WORD_W         = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 8,
  localparam int OFF_W         = clog2(WORDS_PER_LINE),
  localparam int IDX_W         = clog2(LINES),
  localparam int TAG_W         = ADDR_W - IDX_W - OFF_W,
  localparam int LINE_W        = WORD_W * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PRead_request,
  input  logic              PWrite_request,
  input  logic [ADDR_W-1:0] PAddress,
  input  logic [WORD_W-1:0] PWrite_data,
  output logic [WORD_W-1:0] PRead_data,
  output logic              PRead_ready,
  output logic              PWrite_done,
  input  logic              flush,
  output logic              flush_busy,
  output logic              MRead_request,
  input  logic              MRead_ready,
  input  logic [LINE_W-1:0] MRead_data,
  output logic              MWrite_request,
  input  logic              MWrite_done,
  output logic [LINE_W-1:0] MWrite_data,
  output logic [ADDR_W-1:0] MAddress
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              flushing_q, flushing_d;
  logic              is_write_q, is_write_d;

  logic [TAG_W-1:0]  p_tag;
  logic [IDX_W-1:0]  p_idx;
  logic [OFF_W-1:0]  p_off;
  logic [IDX_W-1:0]  idx;
  store_op_t         op;
  logic              merge;
  logic [LINE_W-1:0] rd_line;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid, rd_dirty, hit, victim_dirty;
  logic [WORD_W-1:0] words [WORDS_PER_LINE];

  assign {p_tag, p_idx, p_off} = PAddress;
  assign idx          = flushing_q ? flush_cnt_q : p_idx;
  assign hit          = rd_valid && (rd_tag == p_tag);
  assign victim_dirty = rd_valid && rd_dirty;

  cache_line_store #(
    .WORD_W(WORD_W), .WORDS_PER_LINE(WORDS_PER_LINE), .LINES(LINES),
    .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .LINE_W(LINE_W)
  ) u_store (
    .clk(clk), .rst(rst), .idx(idx), .op(op),
    .wr_line(MRead_data), .wr_tag(p_tag), .wr_off(p_off), .wr_word(PWrite_data),
    .wr_merge(merge), .rd_line(rd_line), .rd_tag(rd_tag),
    .rd_valid(rd_valid), .rd_dirty(rd_dirty)
  );

  for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_rd_word
    assign words[gi] = rd_line[gi*WORD_W +: WORD_W];
  end
  assign PRead_data  = words[p_off];
  assign MWrite_data = (state_q == ST_WRITEBACK) ? rd_line : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      flushing_q  <= 1'b0;
      is_write_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      flushing_q  <= flushing_d;
      is_write_q  <= is_write_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    flushing_d     = flushing_q;
    is_write_d     = is_write_q;
    op             = OP_NONE;
    merge          = 1'b0;
    PRead_ready    = 1'b0;
    PWrite_done    = 1'b0;
    MRead_request  = 1'b0;
    MWrite_request = 1'b0;
    flush_busy     = 1'b0;
    MAddress       = '0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d     = ST_FLUSH;
          flushing_d  = 1'b1;
          flush_cnt_d = '0;
        end else if (PRead_request || PWrite_request) begin
          // A simultaneous read wins; the write is left for a later request.
          is_write_d = !PRead_request;
          if (hit) begin
            state_d = ST_RESPOND;
            if (!PRead_request) op = OP_WORD;
          end else if (victim_dirty) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_REFILL;
          end
        end
      end
      ST_WRITEBACK: begin
        MWrite_request = 1'b1;
        flush_busy     = flushing_q;
        MAddress       = {rd_tag, idx, {OFF_W{1'b0}}};
        if (MWrite_done) begin
          op      = OP_CLEAN;
          state_d = flushing_q ? ST_FLUSH : ST_REFILL;
        end
      end
      ST_REFILL: begin
        MRead_request = 1'b1;
        MAddress      = {p_tag, p_idx, {OFF_W{1'b0}}};
        if (MRead_ready) begin
          op      = OP_FILL;
          merge   = is_write_q;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        PRead_ready = PRead_request && !is_write_q;
        PWrite_done = PWrite_request && is_write_q;
        if (!PRead_request && !PWrite_request) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        flush_busy = 1'b1;
        if (victim_dirty) begin
          state_d = ST_WRITEBACK;
        end else begin
          op = OP_INVAL;
          if (flush_cnt_q == IDX_W'(LINES - 1)) begin
            state_d     = ST_IDLE;
            flushing_d  = 1'b0;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_wb_dm.sv
// Directed and randomized bench for cache_wb_dm with default parameters.
// A software cache/memory model predicts hits, victim write-backs, refills and returned data.
module tb_cache_wb_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        PRead_request, PWrite_request, flush;
  logic [7:0]  PAddress, PWrite_data, PRead_data, MAddress;
  logic        PRead_ready, PWrite_done, flush_busy;
  logic        MRead_request, MRead_ready, MWrite_request, MWrite_done;
  logic [31:0] MRead_data, MWrite_data;

  cache_wb_dm dut (
    .clk(clk), .rst(rst),
    .PRead_request(PRead_request), .PWrite_request(PWrite_request),
    .PAddress(PAddress), .PWrite_data(PWrite_data), .PRead_data(PRead_data),
    .PRead_ready(PRead_ready), .PWrite_done(PWrite_done),
    .flush(flush), .flush_busy(flush_busy),
    .MRead_request(MRead_request), .MRead_ready(MRead_ready), .MRead_data(MRead_data),
    .MWrite_request(MWrite_request), .MWrite_done(MWrite_done),
    .MWrite_data(MWrite_data), .MAddress(MAddress)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: main memory by line address plus the cache contents.
  logic [31:0] mem [64];
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
  endtask

  task automatic access(input logic [7:0] a, input bit wr, input logic [7:0] wd);
    logic [2:0] idx, tg;
    logic [1:0] off;
    bit         hit;
    int         lat;
    idx = a[4:2];
    tg  = a[7:5];
    off = a[1:0];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    PAddress    = a;
    PWrite_data = wd;
    if (wr) PWrite_request = 1'b1;
    else    PRead_request  = 1'b1;
    @(posedge clk); #1;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        chk("wb_req", MWrite_request, 1);
        chk("wb_addr", MAddress, {m_tag[idx], idx, 2'b00});
        chk("wb_data", MWrite_data, m_data[idx]);
        lat = $urandom_range(0, 2);
        repeat (lat) begin
          @(posedge clk); #1;
          chk("wb_hold", MWrite_request, 1);
        end
        MWrite_done = 1'b1;
        @(posedge clk); #1;
        MWrite_done = 1'b0;
        mem[{m_tag[idx], idx}] = m_data[idx];
        m_dirty[idx] = 0;
        chk("wb_drop", MWrite_request, 0);
      end
      chk("rf_req", MRead_request, 1);
      chk("rf_addr", MAddress, {tg, idx, 2'b00});
      chk("rf_early_rdy", PRead_ready | PWrite_done, 0);
      lat = $urandom_range(0, 3);
      repeat (lat) begin
        @(posedge clk); #1;
        chk("rf_hold", MRead_request, 1);
      end
      MRead_data  = mem[{tg, idx}];
      MRead_ready = 1'b1;
      @(posedge clk); #1;
      MRead_ready = 1'b0;
      MRead_data  = $urandom;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
      m_data[idx]  = mem[{tg, idx}];
      chk("rf_drop", MRead_request, 0);
    end else begin
      chk("hit_nomem", MRead_request | MWrite_request, 0);
    end
    if (wr) begin
      m_data[idx][off*8 +: 8] = wd;
      m_dirty[idx] = 1;
      chk("wdone", PWrite_done, 1);
      chk("wdone_no_rready", PRead_ready, 0);
    end else begin
      chk("rready", PRead_ready, 1);
      chk("rdata", PRead_data, m_data[idx][off*8 +: 8]);
    end
    PRead_request  = 1'b0;
    PWrite_request = 1'b0;
    @(posedge clk); #1;
    chk("back_idle", PRead_ready | PWrite_done | MRead_request | MWrite_request, 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("fl_busy", flush_busy, 1);
      chk("fl_nowb", MWrite_request, 0);
      if (m_valid[i] && m_dirty[i]) begin
        @(posedge clk); #1;
        chk("fl_wb_req", MWrite_request, 1);
        chk("fl_wb_busy", flush_busy, 1);
        chk("fl_wb_addr", MAddress, {m_tag[i], 3'(i), 2'b00});
        chk("fl_wb_data", MWrite_data, m_data[i]);
        MWrite_done = 1'b1;
        @(posedge clk); #1;
        MWrite_done = 1'b0;
        mem[{m_tag[i], 3'(i)}] = m_data[i];
      end
      @(posedge clk); #1;
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    chk("fl_done", flush_busy, 0);
    chk("fl_no_mreq", MRead_request | MWrite_request, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    int         r;
    rst = 1'b1;
    PRead_request = 0; PWrite_request = 0; flush = 0;
    PAddress = 0; PWrite_data = 0;
    MRead_ready = 0; MWrite_done = 0; MRead_data = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[6'h09] = 32'hDDCCBBAA;
    mem[6'h20] = 32'h0000_0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mreq", MRead_request | MWrite_request, 0);
    chk("rst_pready", PRead_ready | PWrite_done, 0);
    chk("rst_busy", flush_busy, 0);

    // Cold read, hit read, write hit, dirty eviction, write miss with merge.
    access(8'h25, 0, 8'h00);
    chk("cold_rdata_last", m_data[1], 32'hDDCCBBAA);
    access(8'h27, 0, 8'h00);
    access(8'h26, 1, 8'h5A);
    access(8'h45, 0, 8'h00);
    chk("victim_in_mem", mem[6'h09], 32'hDD5ABBAA);
    access(8'h81, 1, 8'h3C);
    chk("merged_line", m_data[0], 32'h00003C00);
    do_flush();
    chk("flushed_mem", mem[6'h20], 32'h00003C00);

    // Read and write raised together: only the read is answered.
    PAddress = 8'h25; PWrite_data = 8'h77;
    PRead_request = 1; PWrite_request = 1;
    @(posedge clk); #1;
    chk("both_refill", MRead_request, 1);
    MRead_data = mem[6'h09]; MRead_ready = 1;
    @(posedge clk); #1;
    MRead_ready = 0;
    chk("both_rready", PRead_ready, 1);
    chk("both_no_wdone", PWrite_done, 0);
    chk("both_rdata", PRead_data, 8'hBB);
    @(posedge clk); #1;
    chk("both_wdone_wait", PWrite_done, 0);
    PRead_request = 0; PWrite_request = 0;
    @(posedge clk); #1;
    m_valid[1] = 1; m_dirty[1] = 0; m_tag[1] = 3'd1; m_data[1] = mem[6'h09];
    access(8'h25, 1, 8'h77);
    access(8'h25, 0, 8'h00);

    // Replace line 1 with 0xA4 (dirty victim), then reset in the middle of refilling 0x25.
    access(8'hA4, 0, 8'h00);
    PAddress = 8'h25; PRead_request = 1;
    @(posedge clk); #1;
    chk("rst_refill_req", MRead_request, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_drop", MRead_request, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    PRead_request = 0;
    model_reset();
    chk("rst_mid_busy", flush_busy, 0);
    chk("rst_mid_pready", PRead_ready, 0);
    access(8'h25, 0, 8'h00);

    // Randomized traffic with occasional flushes.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 24);
      ra = 8'($urandom_range(0, 3) * 32 + $urandom_range(0, 31));
      if (r == 0) do_flush();
      else access(ra, bit'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_wb_dm.md
# cache_wb_dm

Parametrised direct-mapped, write-back, write-allocate cache between the processor port and the block-wide memory port. Generalises the 8-line/4-byte cache to configurable address width, word width, line size and line count. Adds dirty tracking with victim write-back, and a software flush that writes back every dirty line.

## Interface
- ADDR_W, 8, processor word-address width
- WORD_W, 8, processor data width
- WORDS_PER_LINE, 4, words per line (power of 2, ≥2)
- LINES, 8, number of lines (power of 2, ≥2)
- Derived: OFF_W=log2(WORDS_PER_LINE), IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W-OFF_W (must be ≥1), LINE_W=WORD_W*WORDS_PER_LINE
- Reset: one clock; reset is asynchronous and active-high (ports `clk`, `rst`)
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- PRead_request  in  1  processor read, held until PRead_ready
- PWrite_request  in  1  processor write, held until PWrite_done
- PAddress  in  ADDR_W  {tag, index, offset}
- PWrite_data  in  WORD_W  write word
- PRead_data  out  WORD_W  addressed word of indexed line
- PRead_ready  out  1  read complete
- PWrite_done  out  1  write complete
- flush  in  1  start flush (sampled in IDLE only)
- flush_busy  out  1  flush in progress
- MRead_request  out  1  line fetch
- MRead_ready  in  1  MRead_data valid
- MRead_data  in  LINE_W  fetched line, word 0 in LSBs
- MWrite_request  out  1  line write-back
- MWrite_done  in  1  write-back accepted
- MWrite_data  out  LINE_W  victim line
- MAddress  out  ADDR_W  line address, offset bits zero

## Operation
- Storage per line: data[LINE_W], tag[TAG_W], valid, dirty. Reset clears all valid and dirty bits; data and tag arrays are not reset.
- hit = valid[idx] & (tag[idx]==p_tag).
- States: IDLE, WRITEBACK, REFILL, RESPOND, FLUSH.
- IDLE priority: flush > read > write (a read and write raised together services the read; the write stays pending).
- IDLE, hit → RESPOND. On a write hit, the offset word is written and dirty is set on the same edge.
- IDLE, miss, victim clean or invalid → REFILL.
- IDLE, miss, victim valid & dirty → WRITEBACK.
- WRITEBACK: MWrite_request=1, MAddress={victim tag, idx, 0}, MWrite_data=data[idx]. On MWrite_done → clear dirty, go to REFILL (or return to FLUSH when flushing).
- REFILL: MRead_request=1, MAddress={p_tag, idx, 0}. On MRead_ready: load line, tag, valid=1, dirty=0. A pending write also merges its word and sets dirty on that edge. Then → RESPOND.
- RESPOND: PRead_ready = PRead_request; PWrite_done = PWrite_request. Stay until both requests are low, then → IDLE.
- FLUSH: index counter scans 0..LINES-1, one index per cycle. A dirty line → WRITEBACK, then resume at the same index (now clean). Valid is cleared at every index. After the last index → IDLE. flush_busy=1 in FLUSH and in any write-back inside a flush.
- Processor address and data must stay stable while a request is high. Changing them is unsupported.

## Timing
- Reset values: state IDLE, every output control 0, flush counter 0. MAddress/MWrite_data/PRead_data are don't-care but X-free after the first refill.
- Hit: request sampled at edge N; ready/done high from after edge N (1 cycle).
- Clean miss: 1 cycle + memory latency + 1. MRead_ready may arrive in the first REFILL cycle.
- Dirty miss adds the write-back handshake. MWrite_request holds until MWrite_done. MWrite_done arriving the same cycle as the request is legal.
- Memory requests are level signals. They drop the cycle after ready/done is sampled.
- rst mid-operation clears state immediately; memory requests drop asynchronously. A line under refill stays invalid, and a write-back in flight is abandoned (its dirty data is lost).
- flush asserted while busy is ignored. flush is a level signal; re-assertion after completion starts a new flush.

## Structure
- Package cache_wb_pkg: state enum and a clog2 function for derived widths.
- Sub-module cache_line_store: data/tag/valid/dirty arrays with one read index and one write port, plus a whole-line load and word-merge write. The FSM, flush counter and muxing stay in cache_wb_dm.

## Test plan
- Defaults. Read 8'h25 cold → MRead_request, MAddress 8'h24. Return 32'hDDCCBBAA → PRead_data 8'hBB, PRead_ready one cycle after MRead_ready.
- Read 8'h27 after the above → hit, no MRead_request, PRead_data 8'hDD, ready after one cycle.
- Write 8'h26=8'h5A (hit) → PWrite_done after one cycle. Then read 8'h45 → MWrite_request with MAddress 8'h24 and MWrite_data 32'hDD5ABBAA. After MWrite_done, MRead_request at 8'h44.
- Write miss 8'h81=8'h3C, memory returns 32'h0 → line becomes 32'h00003C00 with dirty set. flush → exactly one write-back (8'h80); flush_busy falls after LINES scan cycles plus the handshake; all lines are invalid.
- Read and write high together at 8'h25 → read serviced first; the write completes only after the requests drop and it is re-raised.
- rst pulse during REFILL at 8'h25 → MRead_request drops immediately; a subsequent read of 8'h25 misses again.
